// File: rtl/riscv_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_muldiv_pkg
// Shared types and helpers for the iterative RV32M/RV64M multiply/divide unit.
//   muldiv_op_e    : funct3 encodings of the M-extension operations
//   muldiv_state_e : control states of the unit
//   is_div / is_rem / op_a_signed / op_b_signed : operation decode helpers
// -----------------------------------------------------------------------------
package riscv_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  // Any of DIV/DIVU/REM/REMU.
  function automatic logic is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // REM/REMU select the remainder instead of the quotient.
  function automatic logic is_rem(input muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // rs1 is interpreted as two's complement.
  function automatic logic op_a_signed(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is interpreted as two's complement.
  function automatic logic op_b_signed(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  // Signed division flavour (DIV/REM); this is the signedness tag kept
  // alongside the reuse operands.
  function automatic logic is_signed_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/riscv_muldiv.sv
// -----------------------------------------------------------------------------
// riscv_muldiv
// Iterative radix-2 multiply/divide unit for the execute stage.
// Multiply is shift-add on magnitudes, divide is restoring division on
// magnitudes; the sign is applied once in the FIX state. Division by zero,
// signed overflow and a repeat of the last division (DIV after REM or vice
// versa with identical operands) complete without iterating.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   start  : request strobe, accepted only in IDLE
//   op     : funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1    : operand A (multiplicand / dividend)
//   rs2    : operand B (multiplier / divisor)
//   flush  : abort the in-flight operation
//   busy   : operation in progress (CALC/FIX)
//   done   : one-cycle completion pulse
//   result : registered result, held until the next completion
// -----------------------------------------------------------------------------
module riscv_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  muldiv_state_e     r_state;
  muldiv_state_e     w_state_next;
  muldiv_op_e        r_op;
  logic [DATA_W-1:0] r_rs1;
  logic [DATA_W-1:0] r_rs2;
  logic [CNT_W-1:0]  r_cnt;
  // r_hi:r_lo is the 2*DATA_W product (multiplier shifts out of r_lo) or
  // partial remainder : dividend/quotient (quotient bits shift into r_lo).
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  // Magnitude of rs2: addend for multiply, divisor for divide.
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_result;

  logic              r_reuse_vld;
  logic [DATA_W-1:0] r_reuse_a;
  logic [DATA_W-1:0] r_reuse_b;
  logic              r_reuse_signed;
  logic [DATA_W-1:0] r_reuse_q;
  logic [DATA_W-1:0] r_reuse_r;

  // ---------------------------------------------------------------------------
  // Request decode (IDLE)
  // ---------------------------------------------------------------------------
  muldiv_op_e        w_op;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_abs_a;
  logic [DATA_W-1:0] w_abs_b;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_reuse_hit;
  logic              w_fast;
  logic [DATA_W-1:0] w_fast_res;

  always_comb begin
    w_op        = muldiv_op_e'(op);
    w_a_neg     = op_a_signed(w_op) & rs1[DATA_W-1];
    w_b_neg     = op_b_signed(w_op) & rs2[DATA_W-1];
    w_abs_a     = w_a_neg ? -rs1 : rs1;
    w_abs_b     = w_b_neg ? -rs2 : rs2;
    w_div_zero  = is_div(w_op) && (rs2 == '0);
    w_div_ovf   = is_signed_div(w_op) && (rs1 == MIN_NEG) && (rs2 == '1);
    w_reuse_hit = is_div(w_op) && r_reuse_vld &&
                  (rs1 == r_reuse_a) && (rs2 == r_reuse_b) &&
                  (is_signed_div(w_op) == r_reuse_signed);
    w_fast      = w_div_zero | w_div_ovf | w_reuse_hit;

    // Divide-by-zero has priority: a reuse entry never holds a zero divisor,
    // and overflow needs rs2 = all-ones, so the three cases are disjoint in
    // practice; the ordering only documents intent.
    w_fast_res = '0;
    if (w_div_zero) begin
      w_fast_res = is_rem(w_op) ? rs1 : '1;
    end else if (w_div_ovf) begin
      w_fast_res = is_rem(w_op) ? '0 : rs1;
    end else if (w_reuse_hit) begin
      w_fast_res = is_rem(w_op) ? r_reuse_r : r_reuse_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Iteration step (CALC)
  // ---------------------------------------------------------------------------
  logic [DATA_W:0] w_mul_sum;
  logic [DATA_W:0] w_div_shift;
  logic [DATA_W:0] w_div_diff;

  always_comb begin
    // Shift-add: add the multiplicand when the current multiplier bit is set;
    // the carry becomes the new MSB after the right shift.
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    // Restoring step: bring in the next dividend bit and trial-subtract.
    // The remainder is always below the divisor, so DATA_W+1 bits suffice.
    w_div_shift = {r_hi, r_lo[DATA_W-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opb};
  end

  // ---------------------------------------------------------------------------
  // Sign correction and result selection (FIX)
  // ---------------------------------------------------------------------------
  logic                r_a_neg_w;
  logic                r_b_neg_w;
  logic [2*DATA_W-1:0] w_prod;
  logic [2*DATA_W-1:0] w_prod_fix;
  logic [DATA_W-1:0]   w_quo_fix;
  logic [DATA_W-1:0]   w_rem_fix;
  logic [DATA_W-1:0]   w_fix_res;

  always_comb begin
    r_a_neg_w  = op_a_signed(r_op) & r_rs1[DATA_W-1];
    r_b_neg_w  = op_b_signed(r_op) & r_rs2[DATA_W-1];
    w_prod     = {r_hi, r_lo};
    w_prod_fix = (r_a_neg_w ^ r_b_neg_w) ? -w_prod : w_prod;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    w_quo_fix  = (r_a_neg_w ^ r_b_neg_w) ? -r_lo : r_lo;
    w_rem_fix  = r_a_neg_w ? -r_hi : r_hi;

    if (is_div(r_op)) begin
      w_fix_res = is_rem(r_op) ? w_rem_fix : w_quo_fix;
    end else if (r_op == OP_MUL) begin
      w_fix_res = w_prod_fix[DATA_W-1:0];
    end else begin
      w_fix_res = w_prod_fix[2*DATA_W-1:DATA_W];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        // flush wins over a simultaneous request
        if (start && !flush) begin
          w_state_next = w_fast ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (flush) begin
          w_state_next = ST_IDLE;
        end else if (r_cnt == CNT_ONE) begin
          w_state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        w_state_next = flush ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        // A start seen here is dropped; the core re-issues it.
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and reuse store
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op           <= OP_MUL;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_cnt          <= '0;
      r_hi           <= '0;
      r_lo           <= '0;
      r_opb          <= '0;
      r_result       <= '0;
      r_reuse_vld    <= 1'b0;
      r_reuse_a      <= '0;
      r_reuse_b      <= '0;
      r_reuse_signed <= 1'b0;
      r_reuse_q      <= '0;
      r_reuse_r      <= '0;
    end else begin
      if (flush) begin
        r_reuse_vld <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (start && !flush) begin
            r_op  <= w_op;
            r_rs1 <= rs1;
            r_rs2 <= rs2;
            r_cnt <= CNT_INIT;
            r_hi  <= '0;
            r_lo  <= w_abs_a;
            r_opb <= w_abs_b;
            if (w_fast) begin
              r_result <= w_fast_res;
            end
          end
        end

        ST_CALC: begin
          if (!flush) begin
            r_cnt <= r_cnt - CNT_ONE;
            if (is_div(r_op)) begin
              r_hi <= w_div_diff[DATA_W] ? w_div_shift[DATA_W-1:0]
                                         : w_div_diff[DATA_W-1:0];
              r_lo <= {r_lo[DATA_W-2:0], ~w_div_diff[DATA_W]};
            end else begin
              r_hi <= w_mul_sum[DATA_W:1];
              r_lo <= {w_mul_sum[0], r_lo[DATA_W-1:1]};
            end
          end
        end

        ST_FIX: begin
          if (!flush) begin
            r_result <= w_fix_res;
            if (is_div(r_op)) begin
              r_reuse_vld    <= 1'b1;
              r_reuse_a      <= r_rs1;
              r_reuse_b      <= r_rs2;
              r_reuse_signed <= is_signed_div(r_op);
              r_reuse_q      <= w_quo_fix;
              r_reuse_r      <= w_rem_fix;
            end else begin
              r_reuse_vld <= 1'b0;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign busy   = (r_state == ST_CALC) || (r_state == ST_FIX);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_riscv_muldiv.sv
module tb_riscv_muldiv;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam int NORM_LAT = 34;
  localparam int MAX_WAIT = 100;

  string op_names [8] = '{"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};

  always #5 clk = ~clk;

  riscv_muldiv #(.DATA_W(32)) dut (
    .clk    (clk),
    .reset  (reset_n),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain 64-bit arithmetic from the ISA rules.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          ub;
    longint unsigned uua;
    longint unsigned uub;
    logic [63:0]     p;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    uua = {32'd0, a};
    uub = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = uua * uub;    return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one request and wait for done. lat counts edges from the edge that
  // samples start (1 = done visible right after that edge).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic busy1);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy1 = busy;
    lat   = 1;
    while (!done && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
  endtask

  task automatic run_and_check(input string name, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int          lat;
    logic        busy1;
    run_op(o, a, b, res, lat, busy1);
    $display("%s %s a=0x%08h b=0x%08h -> 0x%08h lat=%0d (exp 0x%08h lat=%0d)",
             name, op_names[o], a, b, res, lat, exp_res, exp_lat);
    check({name, "_result"}, res, exp_res);
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy"}, busy1, (exp_lat > 1));
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, done, 1'b0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  o;
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic        rv;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rsg;
    logic        fast;
    logic        saw_done;
    int          lat;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 34};
    vecs[2]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    vecs[3]  = '{3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    vecs[4]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[5]  = '{3'd4, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1};
    vecs[6]  = '{3'd7, 32'h1234_5678,  32'd0,         32'h1234_5678, 1};
    vecs[7]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[8]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[9]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    vecs[10] = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1};
    vecs[11] = '{3'd0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFF2, 34};
    vecs[12] = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[13] = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
    vecs[14] = '{3'd7, 32'd100,        32'd7,         32'd2,         1};
    vecs[15] = '{3'd4, 32'd100,        32'd7,         32'd14,        34};

    reset_n = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    op      = 3'd0;
    rs1     = '0;
    rs2     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // ---- directed table ----
    for (int i = 0; i < 16; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
    end

    // ---- flush during CALC ----
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    saw_done = done;
    repeat (40) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | done;
    end
    $display("flush DIVU 1000/3 -> done_seen=%0d result=0x%08h", saw_done, result);
    check("flush_no_done", saw_done, 1'b0);
    check("flush_result_hold", result, 32'd14);
    // flush cleared the reuse entry left by vec15
    run_and_check("after_flush", 3'd4, 32'd100, 32'd7, 32'd14, NORM_LAT);

    // ---- start held through CALC and into DONE ----
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd6;
    @(posedge clk);
    #1;
    op = 3'd3; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF;
    lat = 1;
    while (!done && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("held-start MUL 5*6 -> 0x%08h lat=%0d", result, lat);
    check("hold_latency", 64'(lat), 64'(NORM_LAT));
    check("hold_result", result, 32'd30);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_start_busy", busy, 1'b0);
    check("done_start_done", done, 1'b0);

    // ---- async reset mid-CALC ----
    @(negedge clk);
    start = 1'b1; op = 3'd1; rs1 = 32'd3; rs2 = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    #1;
    $display("reset mid-CALC -> busy=%0d done=%0d result=0x%08h", busy, done, result);
    check("midreset_busy", busy, 1'b0);
    check("midreset_done", done, 1'b0);
    check("midreset_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_and_check("post_reset", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NORM_LAT);

    // ---- randomized against reference model ----
    rv = 1'b0; ra = '0; rb = '0; rsg = 1'b0;
    last_a = 32'd12345; last_b = 32'd67;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0: begin o = 3'($urandom_range(4, 7)); a = $urandom; b = 32'd0; end
        1: begin o = ($urandom_range(0, 1) != 0) ? 3'd4 : 3'd6; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin o = 3'($urandom_range(4, 7)); a = last_a; b = last_b; end
        3: begin o = 3'($urandom_range(0, 7)); a = $urandom; b = 32'($urandom_range(1, 15)); end
        default: begin o = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; end
      endcase
      fast = o[2] && ((b == 32'd0) ||
                      ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
                      (rv && a == ra && b == rb && ((o == 3'd4 || o == 3'd6) == rsg)));
      run_and_check($sformatf("rnd%0d", i), o, a, b, ref_res(o, a, b), fast ? 1 : NORM_LAT);
      if (!o[2]) begin
        rv = 1'b0;
      end else if (!fast) begin
        rv = 1'b1; ra = a; rb = b; rsg = (o == 3'd4 || o == 3'd6);
      end
      last_a = a;
      last_b = b;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv.md
Name: riscv_muldiv

Overview:
Parametrised iterative multiply/divide unit adding RV32M/RV64M execution to the riscv core. It sits beside the ALU in the Datapath execute stage and is started by a one-cycle request. The core stalls while busy is high. The unit adds behaviour the single-cycle ALU path lacks: multi-cycle operation, kill/flush, special-case fast paths and DIV/REM result reuse.

Parameters:
DATA_W, 32, operand and result width; must be even, at least 8.
CNT_W, $clog2(DATA_W+1), width of the iteration counter; derived, not overridden.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
start  in  1  request strobe; sampled only while busy=0.
op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rs1  in  DATA_W  operand A (multiplicand / dividend).
rs2  in  DATA_W  operand B (multiplier / divisor).
flush  in  1  kill the in-flight operation (branch mispredict / trap).
busy  out  1  operation in progress; core must stall.
done  out  1  one-cycle pulse; result valid in the same cycle.
result  out  DATA_W  registered result; holds until the next done.

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, done=0, result=0, the reuse-valid flag is cleared, and all working registers are cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE + start: latch op, rs1 and rs2.
  - If the operation is a fast-path case, go to DONE. Otherwise go to CALC and load counter = DATA_W.
  - busy goes high on the edge that samples start.
- CALC: one radix-2 step per cycle; counter decrements and reaching 0 moves to FIX.
  - Multiply: shift-add on absolute values with a 2*DATA_W product.
  - Divide: restoring division on absolute values.
- FIX: apply the sign correction, select the low or high product half or the quotient/remainder, write result, then go to DONE.
- DONE: done=1 and busy=0 for exactly this cycle, then IDLE.
- Normal latency: done is high in the cycle DATA_W+2 edges after the start edge.
- Fast-path latency: done is high in the cycle 1 edge after the start edge.
- Sign rules:
  - MULH: signed x signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both unsigned.
  - DIV/REM: signed, quotient truncated toward zero, remainder takes the dividend's sign.
- Fast paths (no CALC):
  - Divisor = 0: DIV/DIVU return all-ones; REM/REMU return rs1.
  - Signed overflow (rs1 = most-negative, rs2 = all-ones, DIV/REM): DIV returns rs1; REM returns 0.
  - Reuse: op is DIV/DIVU/REM/REMU, reuse-valid=1, and rs1/rs2/signedness match the last completed normal division. Return the stored quotient or remainder.
- Reuse store: every completed normal division stores quotient, remainder, operands and signedness, then sets reuse-valid. Any completed multiply, flush or reset clears reuse-valid.
- start while busy=1: ignored. No queueing, and latched operands are unchanged.
- start in the DONE cycle: ignored, because busy=0 but state is not IDLE. The core re-issues the request.
- flush=1 in CALC or FIX: next state is IDLE, no done, and result is unchanged.
- flush in DONE: done still pulses.
- flush and start together in IDLE: flush wins and the request is dropped.
- Reset mid-operation: immediate abort to reset values.
- All arithmetic is internal at DATA_W+1 bits for divide and 2*DATA_W bits for multiply. There is no overflow flag.

Decomposition:
- Package riscv_muldiv_pkg holds:
  - typedef enum logic[2:0] muldiv_op_e: the eight funct3 codes.
  - typedef enum logic[1:0] muldiv_state_e: IDLE, CALC, FIX, DONE.
  - Helper function is_div(op).
- Single module. The shared shifter/adder datapath does not split cleanly, so no sub-module is required.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD (-3), DATA_W=32 -> done 34 cycles after start, result=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF.
- MULH, rs1=rs2=0x80000000 -> result 0x40000000; MULHU same operands -> 0x40000000; MULHSU, rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV and REMU with rs2=0, rs1=0x12345678 -> DIV returns 0xFFFFFFFF and REMU returns 0x12345678, each with done 1 cycle after start. Then DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 (1 cycle) and REM -> 0.
- DIV, rs1=-7, rs2=2 -> 0xFFFFFFFD after 34 cycles; then REM with the same operands -> 0xFFFFFFFF with done after 1 cycle (reuse). Then MUL, then REM with the same operands again -> 34 cycles (reuse cleared).
- Start DIVU, flush at cycle 10 -> busy low next edge, no done, result holds its prior value. A start held high during CALC of another operation is ignored.
- Assert reset at cycle 5 of CALC -> busy, done and result 0 asynchronously. After release, MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
